// File: rtl/ip_hash_query_ctrl.sv
// Linear-probing hash query controller: folds an IPv4 address into a table key,
// probes up to MAX_PROBE consecutive slots, and performs lookup or insert.
package ip_hash_query_pkg;
   typedef enum logic {
      LOOK_UP_QUERY = 1'b0,
      INSERT_QUERY  = 1'b1
   } hash_query_t;
endpackage

module ip_hash_query_ctrl
   import ip_hash_query_pkg::*;
#(
   parameter int KEY_W     = 12,
   parameter int VAL_W     = 32,
   parameter int MAX_PROBE = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic                           req_op_i,
   input  logic [VAL_W-1:0]               req_ip_i,
   output logic                           ht_wr_en_o,
   output hash_query_t                    ht_query_o,
   output logic [KEY_W-1:0]               ht_key_o,
   output logic [VAL_W-1:0]               ht_val_o,
   input  logic                           ht_resp_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic                           rsp_op_o,
   output logic                           rsp_hit_o,
   output logic [KEY_W-1:0]               rsp_key_o,
   output logic [$clog2(MAX_PROBE+1)-1:0] rsp_probes_o,
   output logic [2:0]                     dbg_state_o
);

   localparam int PROBE_W = $clog2(MAX_PROBE+1);
   localparam int N_CHUNK = (VAL_W + KEY_W - 1) / KEY_W;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      QUERY  = 3'd1,
      WAIT   = 3'd2,
      WRITE  = 3'd3,
      RESULT = 3'd4
   } state_t;

   // XOR of all KEY_W-wide chunks of the address, top chunk zero-padded.
   function automatic logic [KEY_W-1:0] fold_hash(input logic [VAL_W-1:0] ip);
      logic [N_CHUNK*KEY_W-1:0] padded;
      logic [KEY_W-1:0]         h;
      padded            = '0;
      padded[VAL_W-1:0] = ip;
      h                 = '0;
      for (int i = 0; i < N_CHUNK; i++) begin
         h = h ^ padded[i*KEY_W +: KEY_W];
      end
      return h;
   endfunction

   state_t              state_q, state_d;
   logic                op_q, op_d;
   logic [VAL_W-1:0]    ip_q, ip_d;
   logic [KEY_W-1:0]    key_q, key_d;
   logic [PROBE_W-1:0]  probe_q, probe_d;
   logic                hit_q, hit_d;
   logic                init_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= 1'b0;
         ip_q    <= '0;
         key_q   <= '0;
         probe_q <= '0;
         hit_q   <= 1'b0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ip_q    <= ip_d;
         key_q   <= key_d;
         probe_q <= probe_d;
         hit_q   <= hit_d;
         init_q  <= 1'b1;
      end
   end

   // Handshakes: a transfer happens on a clock edge where valid and ready are both
   // high; valid never waits on ready, and rsp_* stay frozen while rsp_valid_o is
   // high and rsp_ready_i is low.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ip_d    = ip_q;
      key_d   = key_q;
      probe_d = probe_q;
      hit_d   = hit_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i && init_q) begin
               op_d    = req_op_i;
               ip_d    = req_ip_i;
               key_d   = fold_hash(req_ip_i);
               probe_d = '0;
               hit_d   = 1'b0;
               // Address zero marks an empty slot, so it can never be stored.
               state_d = (req_ip_i == '0) ? RESULT : QUERY;
            end
         end
         QUERY: begin
            probe_d = probe_q + PROBE_W'(1);
            state_d = WAIT;
         end
         WAIT: begin
            if (ht_resp_i) begin
               if (op_q) begin
                  state_d = WRITE;
               end else begin
                  hit_d   = 1'b1;
                  state_d = RESULT;
               end
            end else if (probe_q == PROBE_W'(MAX_PROBE)) begin
               hit_d   = 1'b0;
               state_d = RESULT;
            end else begin
               key_d   = key_q + KEY_W'(1);
               state_d = QUERY;
            end
         end
         WRITE: begin
            hit_d   = 1'b1;
            state_d = RESULT;
         end
         RESULT: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready_o  = (state_q == IDLE) && init_q;
   assign ht_wr_en_o   = (state_q == WRITE);
   assign ht_query_o   = op_q ? INSERT_QUERY : LOOK_UP_QUERY;
   assign ht_key_o     = key_q;
   assign ht_val_o     = ip_q;
   assign rsp_valid_o  = (state_q == RESULT);
   assign rsp_op_o     = op_q;
   assign rsp_hit_o    = hit_q;
   assign rsp_key_o    = key_q;
   assign rsp_probes_o = probe_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ip_hash_query_ctrl.sv
// Directed bench for ip_hash_query_ctrl with a behavioural hash table that
// answers one cycle after each query and stores on write enable.
module tb_ip_hash_query_ctrl;
  import ip_hash_query_pkg::*;

  localparam int KEY_W = 12;
  localparam int VAL_W = 32;
  localparam int MAX_PROBE = 4;
  localparam int PROBE_W = $clog2(MAX_PROBE+1);

  logic               clk;
  logic               rst_n;
  logic               req_valid_i;
  logic               req_ready_o;
  logic               req_op_i;
  logic [VAL_W-1:0]   req_ip_i;
  logic               ht_wr_en_o;
  hash_query_t        ht_query_o;
  logic [KEY_W-1:0]   ht_key_o;
  logic [VAL_W-1:0]   ht_val_o;
  logic               ht_resp_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic               rsp_op_o;
  logic               rsp_hit_o;
  logic [KEY_W-1:0]   rsp_key_o;
  logic [PROBE_W-1:0] rsp_probes_o;
  logic [2:0]         dbg_state_o;

  int checks = 0;
  int errors = 0;

  ip_hash_query_ctrl #(.KEY_W(KEY_W), .VAL_W(VAL_W), .MAX_PROBE(MAX_PROBE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_ip_i(req_ip_i),
    .ht_wr_en_o(ht_wr_en_o), .ht_query_o(ht_query_o),
    .ht_key_o(ht_key_o), .ht_val_o(ht_val_o), .ht_resp_i(ht_resp_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_op_o(rsp_op_o), .rsp_hit_o(rsp_hit_o),
    .rsp_key_o(rsp_key_o), .rsp_probes_o(rsp_probes_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural hash table
  logic [VAL_W-1:0] mem [4096] = '{default: '0};
  always @(posedge clk) begin
    if (ht_wr_en_o) mem[ht_key_o] <= ht_val_o;
    ht_resp_i <= (ht_query_o == INSERT_QUERY) ? (mem[ht_key_o] == '0)
                                              : (mem[ht_key_o] == ht_val_o);
  end

  // write monitor
  int               wr_cnt = 0;
  logic [KEY_W-1:0] wr_key = '0;
  logic [VAL_W-1:0] wr_val = '0;
  always @(negedge clk) begin
    if (ht_wr_en_o) begin
      wr_cnt = wr_cnt + 1;
      wr_key = ht_key_o;
      wr_val = ht_val_o;
    end
  end

  // scoreboard
  logic [KEY_W-1:0] exp_q[$];
  logic [KEY_W-1:0] got_keys[$];
  int               got_lat;
  logic             got_hit;
  logic             got_op;
  logic [KEY_W-1:0] got_key;
  logic [PROBE_W-1:0] got_probes;
  int               wr_base;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_keys(input string tag);
    check({tag, "_nkeys"}, 32'(got_keys.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_keys.size(); i++)
      check($sformatf("%s_key%0d", tag, i), 32'(got_keys[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  // driver: issue one request, measure latency, log probed keys, capture response
  task automatic do_req(input logic op, input logic [VAL_W-1:0] ip);
    int n;
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_ip_i    = ip;
    got_keys.delete();
    wr_base = wr_cnt;
    @(posedge clk);
    got_lat = 1;
    #1;
    req_valid_i = 1'b0;
    while (!rsp_valid_o && got_lat < 40) begin
      if (got_lat % 2 == 1 && !ht_wr_en_o) got_keys.push_back(ht_key_o);
      @(posedge clk);
      got_lat++;
      #1;
    end
    check("rsp_timeout", 32'(rsp_valid_o), 32'd1);
    got_hit    = rsp_hit_o;
    got_op     = rsp_op_o;
    got_key    = rsp_key_o;
    got_probes = rsp_probes_o;
    if (rsp_ready_i) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_rsp(input string tag, input logic op, input logic hit,
                           input logic [KEY_W-1:0] key, input int probes, input int lat);
    check({tag, "_op"},     32'(got_op),     32'(op));
    check({tag, "_hit"},    32'(got_hit),    32'(hit));
    check({tag, "_key"},    32'(got_key),    32'(key));
    check({tag, "_probes"}, 32'(got_probes), 32'(probes));
    check({tag, "_lat"},    32'(got_lat),    32'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = 1'b0; req_ip_i = '0;
    rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  32'(req_ready_o),  32'd0);
    check("rst_valid",  32'(rsp_valid_o),  32'd0);
    check("rst_wr_en",  32'(ht_wr_en_o),   32'd0);
    check("rst_query",  32'(ht_query_o),   32'(LOOK_UP_QUERY));
    check("rst_probes", 32'(rsp_probes_o), 32'd0);
    check("rst_state",  32'(dbg_state_o),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(req_ready_o), 32'd1);

    // insert into empty table
    do_req(1'b1, 32'hC0A80001);
    check_rsp("ins1", 1'b1, 1'b1, 12'hA41, 1, 4);
    check("ins1_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
    check("ins1_wr_key", 32'(wr_key), 32'hA41);
    check("ins1_wr_val", wr_val, 32'hC0A80001);

    // lookup after insert
    do_req(1'b0, 32'hC0A80001);
    check_rsp("look1", 1'b0, 1'b1, 12'hA41, 1, 3);
    check("look1_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);

    // colliding insert probes to the next slot
    do_req(1'b1, 32'hC0A81000);
    check_rsp("ins2", 1'b1, 1'b1, 12'hA42, 2, 6);
    check("ins2_wr_key", 32'(wr_key), 32'hA42);
    check("ins2_wr_val", wr_val, 32'hC0A81000);
    exp_q.push_back(12'hA41); exp_q.push_back(12'hA42);
    check_keys("ins2");

    // duplicate insert takes a further slot
    do_req(1'b1, 32'hC0A80001);
    check_rsp("dup", 1'b1, 1'b1, 12'hA43, 3, 8);
    check("dup_wr_key", 32'(wr_key), 32'hA43);

    // absent lookup exhausts all probes
    do_req(1'b0, 32'hC0A82003);
    check_rsp("miss", 1'b0, 1'b0, 12'hA44, 4, 9);
    check("miss_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(12'hA41 + 12'(i));
    check_keys("miss");

    // key wrap from 0xFFF to 0x000
    do_req(1'b1, 32'h00000FFF);
    check_rsp("ins_fff", 1'b1, 1'b1, 12'hFFF, 1, 4);
    do_req(1'b1, 32'h00001FFE);
    check_rsp("wrap", 1'b1, 1'b1, 12'h000, 2, 6);
    check("wrap_wr_key", 32'(wr_key), 32'h000);
    exp_q.push_back(12'hFFF); exp_q.push_back(12'h000);
    check_keys("wrap");
    do_req(1'b0, 32'h00001FFE);
    check_rsp("wrap_look", 1'b0, 1'b1, 12'h000, 2, 5);

    // zero address: no table access, response held under backpressure
    rsp_ready_i = 1'b0;
    do_req(1'b1, 32'h0);
    check_rsp("zero", 1'b1, 1'b0, 12'h000, 0, 1);
    check("zero_nkeys", 32'(got_keys.size()), 32'd0);
    req_valid_i = 1'b1; req_op_i = 1'b0; req_ip_i = 32'hC0A80001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_valid", i), 32'(rsp_valid_o), 32'd1);
      check($sformatf("hold%0d_ready", i), 32'(req_ready_o), 32'd0);
      check($sformatf("hold%0d_hit", i), 32'(rsp_hit_o), 32'd0);
      check($sformatf("hold%0d_probes", i), 32'(rsp_probes_o), 32'd0);
      check($sformatf("hold%0d_key", i), 32'(rsp_key_o), 32'h000);
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("zero_release_valid", 32'(rsp_valid_o), 32'd0);
    check("zero_release_ready", 32'(req_ready_o), 32'd1);
    check("zero_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);

    // reset in the middle of an insert: no write, no response
    wr_base = wr_cnt;
    req_valid_i = 1'b1; req_op_i = 1'b1; req_ip_i = 32'h0A0B0C0D;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
    check("mid_rst_wr_en", 32'(ht_wr_en_o), 32'd0);
    check("mid_rst_query", 32'(ht_query_o), 32'(LOOK_UP_QUERY));
    check("mid_rst_ready", 32'(req_ready_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_post_ready", 32'(req_ready_o), 32'd1);
    check("mid_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
    check("mid_rst_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);
    do_req(1'b0, 32'h0A0B0C0D);
    check_rsp("mid_rst_look", 1'b0, 1'b0, 12'hCBA, 4, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
